// File: rtl/pwm_fade_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_pkg
// Brief    : Shared types, default sizes and the fade step helper for the
//            PWM fade scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_fade_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DIV_W_DEF  = 16;
  localparam int DUTY_W     = 8;
  localparam int IDX_W      = 3;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  // Move cur toward tgt by at most step. The distance is formed in 9 bits so
  // it can never wrap; when the step would overshoot, land exactly on tgt.
  function automatic logic [DUTY_W-1:0] fade_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W:0] diff;
    logic [DUTY_W-1:0] nxt;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      nxt  = (diff <= {1'b0, step}) ? tgt : (cur + step);
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      nxt  = (diff <= {1'b0, step}) ? tgt : (cur - step);
    end
    return nxt;
  endfunction

endpackage : pwm_fade_pkg
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_gen
// Brief    : Fade interval divider; emits a one-cycle tick every tickDiv+1
//            clocks, and nothing at all while tickDiv is zero.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [DIV_W-1:0] tickDiv,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // Count 0..tickDiv and pulse on the wrap; >= recovers if tickDiv shrinks mid-count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (tickDiv == '0) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt >= tickDiv) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule : pwm_tick_gen
`default_nettype wire

// File: rtl/pwm_fade_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_scheduler
// Brief    : Owns the shadow copy of a PWM duty-cycle bank, clears the bank
//            after reset, serves host immediate/fade writes and sweeps all
//            channels on every fade tick, stepping current toward target.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_scheduler
  import pwm_fade_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              hostWrite,
  input  logic [IDX_W-1:0]  hostAddr,
  input  logic [DUTY_W-1:0] hostData,
  input  logic              hostMode,
  input  logic [DIV_W-1:0]  tickDiv,
  input  logic [DUTY_W-1:0] stepSize,
  output logic              hostReady,
  output logic              hostAck,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DUTY_W-1:0] memData,
  output logic [NUM_CH-1:0] fadeActive
);

  localparam logic [IDX_W-1:0] c_LAST_CH   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] c_LAST_SYNC = '1;

  state_t                         r_state, w_state_n;
  logic [IDX_W-1:0]               r_sync_idx, w_sync_idx_n;
  logic [IDX_W-1:0]               r_scan_idx, w_scan_idx_n;
  logic                           r_pend, w_pend_n;
  logic [NUM_CH-1:0][DUTY_W-1:0]  r_cur, w_cur_n;
  logic [NUM_CH-1:0][DUTY_W-1:0]  r_tgt, w_tgt_n;
  logic                           r_ready, w_ready_n;
  logic                           r_ack, w_ack_n;
  logic                           r_we, w_we_n;
  logic [IDX_W-1:0]               r_waddr, w_waddr_n;
  logic [DUTY_W-1:0]              r_wdata, w_wdata_n;
  logic [NUM_CH-1:0]              r_fade, w_fade_n;

  logic                           w_tick;
  logic                           w_accept;
  logic                           w_addr_ok;
  logic [DUTY_W-1:0]              w_step_val;

  pwm_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .resetN  (resetN),
    .tickDiv (tickDiv),
    .tick    (w_tick)
  );

  assign w_accept   = hostWrite & r_ready;
  assign w_addr_ok  = ({1'b0, hostAddr} <= {1'b0, c_LAST_CH});
  assign w_step_val = fade_step(r_cur[r_scan_idx], r_tgt[r_scan_idx], stepSize);

  // State, shadow registers and every output are registered here.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state    <= S_SYNC;
      r_sync_idx <= '0;
      r_scan_idx <= '0;
      r_pend     <= 1'b0;
      r_cur      <= '0;
      r_tgt      <= '0;
      r_ready    <= 1'b0;
      r_ack      <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_fade     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_sync_idx <= w_sync_idx_n;
      r_scan_idx <= w_scan_idx_n;
      r_pend     <= w_pend_n;
      r_cur      <= w_cur_n;
      r_tgt      <= w_tgt_n;
      r_ready    <= w_ready_n;
      r_ack      <= w_ack_n;
      r_we       <= w_we_n;
      r_waddr    <= w_waddr_n;
      r_wdata    <= w_wdata_n;
      r_fade     <= w_fade_n;
    end
  end

  // Next state: bank clear, host service (which stalls the sweep), fade sweep.
  always_comb begin
    w_state_n    = r_state;
    w_sync_idx_n = r_sync_idx;
    w_scan_idx_n = r_scan_idx;
    w_pend_n     = r_pend;
    w_cur_n      = r_cur;
    w_tgt_n      = r_tgt;
    w_ack_n      = 1'b0;
    w_we_n       = 1'b0;
    w_waddr_n    = r_waddr;
    w_wdata_n    = r_wdata;
    w_fade_n     = '0;

    // Host request is served the same way in IDLE and SCAN.
    if (r_state != S_SYNC && w_accept) begin
      w_ack_n = 1'b1;
      if (w_addr_ok) begin
        w_tgt_n[hostAddr] = hostData;
        if (!hostMode) begin
          w_cur_n[hostAddr] = hostData;
          w_we_n            = 1'b1;
          w_waddr_n         = hostAddr;
          w_wdata_n         = hostData;
        end
      end
    end

    case (r_state)
      S_SYNC: begin
        w_we_n       = 1'b1;
        w_waddr_n    = r_sync_idx;
        w_wdata_n    = '0;
        w_sync_idx_n = r_sync_idx + IDX_W'(1);
        if (r_sync_idx == c_LAST_SYNC) begin
          w_state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_tick) begin
          w_state_n    = S_SCAN;
          w_scan_idx_n = '0;
        end
      end
      S_SCAN: begin
        if (w_accept) begin
          // Host owns this cycle; the scan index holds.
          if (w_tick) begin
            w_pend_n = 1'b1;
          end
        end else begin
          if (r_cur[r_scan_idx] != r_tgt[r_scan_idx]) begin
            w_cur_n[r_scan_idx] = w_step_val;
            w_we_n              = 1'b1;
            w_waddr_n           = r_scan_idx;
            w_wdata_n           = w_step_val;
          end
          if (r_scan_idx == c_LAST_CH) begin
            w_scan_idx_n = '0;
            if (r_pend || w_tick) begin
              w_pend_n = 1'b0;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_scan_idx_n = r_scan_idx + IDX_W'(1);
            if (w_tick) begin
              w_pend_n = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_n = S_SYNC;
      end
    endcase

    w_ready_n = (w_state_n != S_SYNC);
    for (int i = 0; i < NUM_CH; i++) begin
      w_fade_n[i] = (w_cur_n[i] != w_tgt_n[i]);
    end
  end

  assign hostReady      = r_ready;
  assign hostAck        = r_ack;
  assign memWriteEnable = r_we;
  assign memAddress     = {{(ADDR_W - IDX_W){1'b0}}, r_waddr};
  assign memData        = r_wdata;
  assign fadeActive     = r_fade;

endmodule : pwm_fade_scheduler
`default_nettype wire
